// File: rtl/cyclic_encoder_pkg.sv
// Shared definitions for the cyclic codec (encoder now, decoder later).
// Package name is cyclic_codec_pkg so the future decoder can import the same
// state type and default code parameters.
package cyclic_codec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    PAR  = 2'd2
  } cyc_state_e;

  localparam int unsigned CYC_N = 7;
  localparam int unsigned CYC_K = 4;
  localparam logic [3:0]  CYC_GEN = 4'b1011;

  function automatic int unsigned cyc_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cyclic_encoder_poly_div_lfsr.sv
// Polynomial-division LFSR: remainder of the serial input stream modulo POLY.
// fb_en=1 divides (message phase); fb_en=0 is a plain left shift with zero
// fill, used to shift the finished remainder out MSB first.
module poly_div_lfsr #(
  parameter int unsigned  DEG  = 3,
  parameter logic [DEG:0] POLY = 4'b1011
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           shift,
  input  logic           din,
  input  logic           fb_en,
  output logic [DEG-1:0] rem
);

  logic [DEG-1:0] rem_q;
  logic [DEG-1:0] rem_d;
  logic           fb;

  // Next remainder: clear wins over shift; feedback taps are POLY without x^DEG.
  always_comb begin
    fb    = fb_en & (din ^ rem_q[DEG-1]);
    rem_d = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (shift) begin
      rem_d = (rem_q << 1) ^ (fb ? POLY[DEG-1:0] : '0);
    end
  end

  // Remainder register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/cyclic_encoder.sv
// Serial systematic (N,K) cyclic-code encoder. Accepts K message bits under
// valid/ready, passes them through, then emits N-K parity bits back to back.
// Optional feature macro: CYCENC_FRAME_CNT_EN adds the frame_cnt port.
module cyclic_encoder
  import cyclic_codec_pkg::*;
#(
  parameter int unsigned  N        = CYC_N,
  parameter int unsigned  K        = CYC_K,
  parameter logic [N-K:0] GEN_POLY = CYC_GEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        data_in,
  output logic        out_valid,
  output logic        data_out,
  output logic        out_last
`ifdef CYCENC_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned DEG   = N - K;
  localparam int unsigned CNT_W = $clog2(cyc_max(K, DEG) + 1);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(DEG - 1);

  if (K == 0 || K >= N) begin : g_bad_k
    $error("cyclic_encoder: K must satisfy 1 <= K < N");
  end
  if (GEN_POLY[DEG] != 1'b1 || GEN_POLY[0] != 1'b1) begin : g_bad_poly
    $error("cyclic_encoder: GEN_POLY must have x^(N-K) and x^0 coefficients set");
  end

  cyc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             data_out_q, data_out_d;
  logic             out_last_q, out_last_d;
  logic             lfsr_clr, lfsr_shift, lfsr_fb_en;
  logic [DEG-1:0]   rem;
  logic             accept;
  logic             unused_rem;

  assign in_ready   = (state_q != PAR);
  assign accept     = in_valid && in_ready;
  assign unused_rem = ^rem;

  poly_div_lfsr #(
    .DEG  (DEG),
    .POLY (GEN_POLY)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lfsr_clr),
    .shift (lfsr_shift),
    .din   (data_in),
    .fb_en (lfsr_fb_en),
    .rem   (rem)
  );

  // Phase sequencing and next values of the registered serial outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    data_out_d  = 1'b0;
    out_last_d  = 1'b0;
    lfsr_clr    = 1'b0;
    lfsr_shift  = 1'b0;
    lfsr_fb_en  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lfsr_shift  = 1'b1;
          out_valid_d = 1'b1;
          data_out_d  = data_in;
          if (K == 1) begin
            state_d = PAR;
            cnt_d   = '0;
          end else begin
            state_d = MSG;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      MSG: begin
        if (accept) begin
          lfsr_shift  = 1'b1;
          out_valid_d = 1'b1;
          data_out_d  = data_in;
          if (cnt_q == K_LAST) begin
            state_d = PAR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PAR: begin
        lfsr_fb_en  = 1'b0;
        lfsr_shift  = 1'b1;
        out_valid_d = 1'b1;
        data_out_d  = rem[DEG-1];
        if (cnt_q == P_LAST) begin
          out_last_d = 1'b1;
          lfsr_clr   = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        lfsr_clr = 1'b1;
      end
    endcase
  end

  // FSM state, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign out_last  = out_last_q;

`ifdef CYCENC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Completed-codeword count, advanced on the edge that issues out_last.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (out_last_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register (wraps naturally).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cyclic_encoder.sv
// Self-checking bench for cyclic_encoder: (7,4) instance with random stimulus
// against a long-division reference model, plus a (15,11) instance.
module tb_cyclic_encoder;

  localparam int N = 7;
  localparam int K = 4;

  logic clk;
  logic rst_n;
  logic in_valid, in_ready, data_in;
  logic out_valid, data_out, out_last;
  logic b_in_valid, b_in_ready, b_data_in;
  logic b_out_valid, b_data_out, b_out_last;
`ifdef CYCENC_FRAME_CNT_EN
  logic [15:0] frame_cnt, b_frame_cnt;
  int exp_frames;
`endif

  int tests;
  int fails;

  logic exp_bit [0:4095];
  int   exp_idx [0:4095];
  int   wr_ptr, rd_ptr;
  logic [31:0] got_word [0:1023];
  int   gw;
  logic [31:0] cur_word;
  logic prev_follow;

  cyclic_encoder #(.N(7), .K(4), .GEN_POLY(4'b1011)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .data_out(data_out),
    .out_last(out_last)
`ifdef CYCENC_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  cyclic_encoder #(.N(15), .K(11), .GEN_POLY(5'b10011)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_data_in), .out_valid(b_out_valid), .data_out(b_data_out),
    .out_last(b_out_last)
`ifdef CYCENC_FRAME_CNT_EN
    , .frame_cnt(b_frame_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: systematic codeword by polynomial long division.
  function automatic logic [31:0] cw_model(input int n, input int k,
                                           input logic [31:0] g, input logic [31:0] msg);
    logic [31:0] rem;
    rem = msg << (n - k);
    for (int i = n - 1; i >= n - k; i--) begin
      if (rem[i]) rem = rem ^ (g << (i - (n - k)));
    end
    return (msg << (n - k)) | rem;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge and check the (7,4) outputs against the model.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      rd_ptr      = wr_ptr;
      prev_follow = 1'b0;
      cur_word    = '0;
      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset data_out", data_out, 0);
      chk("reset out_last", out_last, 0);
`ifdef CYCENC_FRAME_CNT_EN
      exp_frames = 0;
      chk("reset frame_cnt", frame_cnt, 0);
`endif
    end else begin
      if (out_valid) begin
        if (rd_ptr == wr_ptr) begin
          chk("spurious out_valid", out_valid, 0);
        end else begin
          chk("data_out", data_out, exp_bit[rd_ptr]);
          chk("out_last", out_last, exp_idx[rd_ptr] == N - 1);
          chk("in_ready", in_ready,
              !(exp_idx[rd_ptr] >= K - 1 && exp_idx[rd_ptr] <= N - 2));
          prev_follow = (exp_idx[rd_ptr] >= K - 1) && (exp_idx[rd_ptr] < N - 1);
`ifdef CYCENC_FRAME_CNT_EN
          if (exp_idx[rd_ptr] == N - 1) exp_frames = (exp_frames + 1) % 65536;
`endif
          rd_ptr++;
        end
        cur_word = {cur_word[30:0], data_out};
        if (out_last) begin
          got_word[gw] = cur_word;
          gw++;
          cur_word = '0;
        end
      end else begin
        if (prev_follow) chk("parity gap", out_valid, 1);
        prev_follow = 1'b0;
        chk("idle data_out", data_out, 0);
        chk("idle out_last", out_last, 0);
        chk("idle in_ready", in_ready, 1);
      end
`ifdef CYCENC_FRAME_CNT_EN
      chk("frame_cnt", frame_cnt, exp_frames);
`endif
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    data_in  = 1'b0;
    repeat (n) tick();
  endtask

  // Queue the expected codeword, then offer the K message bits, optionally
  // dropping in_valid for stall_len cycles before bit index stall_at.
  task automatic send_frame(input logic [31:0] msg, input int stall_at, input int stall_len);
    logic [31:0] cw;
    int tries;
    cw = cw_model(N, K, 32'b1011, msg);
    for (int j = 0; j < N; j++) begin
      exp_bit[wr_ptr] = cw[N - 1 - j];
      exp_idx[wr_ptr] = j;
      wr_ptr++;
    end
    for (int b = 0; b < K; b++) begin
      if (b == stall_at) begin
        repeat (stall_len) begin
          in_valid = 1'b0;
          data_in  = 1'($urandom);
          tick();
        end
      end
      tries = 0;
      while (1) begin
        in_valid = 1'b1;
        if (in_ready) begin
          data_in = msg[K - 1 - b];
          tick();
          break;
        end
        data_in = 1'($urandom);
        tick();
        tries++;
        if (tries >= 20) begin
          chk("in_ready timeout", in_ready, 1);
          break;
        end
      end
    end
  endtask

  initial begin
    int w0;
    int sent, glen;
    logic [31:0] got_b;
    logic [10:0] msg_b;
    tests = 0; fails = 0;
    wr_ptr = 0; rd_ptr = 0; gw = 0;
    cur_word = '0; prev_follow = 1'b0;
`ifdef CYCENC_FRAME_CNT_EN
    exp_frames = 0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; data_in = 1'b0;
    b_in_valid = 1'b0; b_data_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    idle(2);

    // Message 1000, continuous valid.
    w0 = gw;
    send_frame(4'b1000, -1, 0);
    idle(4);
    chk("t1 words", gw - w0, 1);
    chk("t1 codeword", got_word[w0], 7'b1000101);
`ifdef CYCENC_FRAME_CNT_EN
    chk("t1 frame_cnt", frame_cnt, 1);
`endif

    // Back-to-back frames with in_valid held through parity.
    w0 = gw;
    send_frame(4'b0001, -1, 0);
    send_frame(4'b1111, -1, 0);
    send_frame(4'b0000, -1, 0);
    idle(5);
    chk("t2 words", gw - w0, 3);
    chk("t2 codeword0", got_word[w0], 7'b0001011);
    chk("t2 codeword1", got_word[w0 + 1], 7'b1111111);
    chk("t2 codeword2", got_word[w0 + 2], 7'b0000000);

    // Input stall of 2 cycles after bit 2.
    w0 = gw;
    send_frame(4'b1000, 2, 2);
    idle(5);
    chk("t3 words", gw - w0, 1);
    chk("t3 codeword", got_word[w0], 7'b1000101);

    // Reset during parity of an aborted frame, then message 0001.
    w0 = gw;
    send_frame(4'b1010, -1, 0);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_frame(4'b0001, -1, 0);
    idle(5);
    chk("t4 words", gw - w0, 1);
    chk("t4 codeword", got_word[w0], 7'b0001011);
`ifdef CYCENC_FRAME_CNT_EN
    chk("t4 frame_cnt", frame_cnt, 1);
`endif

    // Random messages, stalls and idle gaps.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      send_frame(32'($urandom_range(0, 15)), $urandom_range(0, K), $urandom_range(0, 3));
    end
    idle(6);
    chk("pending expected bits", wr_ptr - rd_ptr, 0);

    // (15,11), g = x^4 + x + 1, message x^10.
    msg_b = 11'b10000000000;
    sent = 0; glen = 0; got_b = '0;
    for (int i = 0; i < 60; i++) begin
      if (sent < 11 && b_in_ready) begin
        b_in_valid = 1'b1;
        b_data_in  = msg_b[10 - sent];
        sent++;
      end else begin
        b_in_valid = 1'b0;
        b_data_in  = 1'b0;
      end
      tick();
      if (b_out_valid) begin
        got_b = {got_b[30:0], b_data_out};
        glen++;
        if (b_out_last) break;
      end
    end
    chk("B length", glen, 15);
    chk("B codeword", got_b, 15'b100000000001001);
    chk("B vs model", got_b, cw_model(15, 11, 32'b10011, 32'(msg_b)));
`ifdef CYCENC_FRAME_CNT_EN
    tick();
    chk("B frame_cnt", b_frame_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cyclic_encoder.md
# cyclic_encoder

Parametrised serial systematic (N,K) cyclic-code encoder, the generalised successor of the fixed (7,4), g(x)=1+x+x^3 encoder in the codec lab. It accepts a K-bit message one bit per cycle under a valid/ready handshake and emits the N-bit codeword serially: K message bits, then N-K parity bits. Parity is the remainder of m(x)·x^(N-K) divided by a generator polynomial set at elaboration. It sits between the bit source and the channel/decoder model in the codec datapath.

## Interface
- N, 7, codeword length (bits)
- K, 4, message length; 1 ≤ K < N
- GEN_POLY, 4'b1011, generator g(x), width N-K+1, bit i = coeff of x^i; bits N-K and 0 must be 1 (elaboration error otherwise)
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  data_in carries a message bit
- in_ready  out  1  encoder accepts a message bit this cycle
- data_in  in  1  message bit, highest degree first
- out_valid  out  1  data_out carries a codeword bit
- data_out  out  1  codeword bit, highest degree first
- out_last  out  1  marks final (x^0) parity bit of a codeword
- frame_cnt  out  16  completed codewords (only with CYCENC_FRAME_CNT_EN)

## Operation
- Remainder register r[N-K-1:0]; on each accepted bit: fb = data_in ^ r[N-K-1]; r <= {r[N-K-2:0],1'b0} ^ (fb ? GEN_POLY[N-K-1:0] : 0).
- Bit counter cnt, width $clog2(max(K,N-K)+1), wraps to 0 at end of each phase.
- FSM states IDLE, MSG, PAR:
  - IDLE: in_ready=1, r=0. Accepted bit (in_valid&&in_ready) → r updated, cnt=1, go MSG (or PAR if K==1).
  - MSG: in_ready=1. Each accepted bit updates r, cnt++. K-th accepted bit → cnt=0, go PAR. in_valid=0 stalls: r, cnt, state hold, out_valid=0.
  - PAR: in_ready=0, input ignored. Each cycle emit r[N-K-1], shift r left with 0 fill, cnt++. After N-K cycles → IDLE, r=0.
- Message bits pass through unmodified (systematic); data_out=data_in of the accepted bit.
- No output backpressure: parity bits issue on N-K consecutive cycles.
- data_out = 0 whenever out_valid = 0.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, data_out=0, out_last=0, frame_cnt=0, r=0, cnt=0.
- out_valid/data_out/out_last are registered: a bit accepted at edge t appears at outputs from t until t+1.
- First parity bit is output in the cycle after the K-th message bit is output. No gap.
- Next message bit is accepted in the cycle after the last parity bit is output. Minimum frame period is N cycles.
- out_last is high exactly with the x^0 parity bit.
- rst_n low mid-frame: at the next edge all state returns to reset values and the partial codeword is discarded; no out_last is issued.
- in_valid while in PAR: no effect, bit not consumed.

## Configuration
- CYCENC_FRAME_CNT_EN defined: frame_cnt port present. It increments by 1 on the edge that issues out_last and wraps 0xFFFF→0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package cyclic_codec_pkg: state enum (IDLE, MSG, PAR), default constants CYC_N=7, CYC_K=4, CYC_GEN=4'b1011, shared with the future decoder.
- One sub-module poly_div_lfsr (params DEG, POLY; ports clk, rst_n, clr, shift, din, fb_en, rem). fb_en=0 gives the parity shift-out mode.

## Test plan
- (7,4), g=1011, message 1000 continuous valid → data_out 1000101, out_last on 7th bit, frame_cnt=1.
- Messages 0001, 1111, 0000 back-to-back → 0001011, 1111111, 0000000. in_ready low exactly 3 cycles per frame.
- Message 1000 with in_valid deasserted 2 cycles after bit 2 → same codeword 1000101. out_valid gap of 2 cycles, no corruption.
- rst_n low for 1 cycle during parity of frame 1, then message 0001 → 0001011. No out_last for the aborted frame, frame_cnt counts only the completed frame.
- in_valid held high through PAR → extra bits not consumed. The next frame starts only after out_last.
- Re-parameterise N=15, K=11, GEN_POLY=5'b10011; message 10000000000 → parity equals x^14 mod g = 1001. Codeword 100000000001001.
